response_sender_uart: RTL and testbench
=======================================

Name: response_sender_uart

Overview:
Transmit-side counterpart of the UART command path. Accepts one register response (address word plus multi-word data value) through a valid/ready handshake. Serializes it as a fixed-length byte frame on a UART TX line: address word first, then data words MSB-word first. Sits beside the command parser and returns readback values to the host over the same 8N1 link.

Parameters:
WORD_WIDTH, 8, bits per UART character and per address/data word
VALUE_WORDS, 4, number of data words per response; data bus width is VALUE_WORDS*WORD_WIDTH
DIVISOR, 100, clk cycles per UART bit; legal range >= 2

Ports:
clk  input  1  clock, all logic on rising edge
i_reset  input  1  synchronous reset, active-low (0 = reset)
i_addr  input  WORD_WIDTH  response address, sampled on accept
i_data  input  VALUE_WORDS*WORD_WIDTH  response value, sampled on accept
i_valid  input  1  response offered
o_ready  output  1  block can accept a response this cycle
o_tx  output  1  UART serial line, idle high
o_busy  output  1  frame in progress (inverse of o_ready)

Behaviour:
- Reset (i_reset=0 at a rising edge): o_tx=1, o_ready=1, o_busy=0; all counters cleared; any in-flight frame is abandoned, with no partial stop bit.
- Accept: i_valid && o_ready at an edge. The block captures i_addr/i_data into a shift register. o_ready drops the following cycle. i_valid while o_ready=0 is ignored; no queueing.
- Frame byte order: byte 0 = addr; bytes 1..VALUE_WORDS = i_data[top word] down to i_data[word 0].
- Character format: 1 start bit (0), WORD_WIDTH data bits LSB first, 1 stop bit (1).
- Each bit is held exactly DIVISOR cycles. Character time = (WORD_WIDTH+2)*DIVISOR cycles.
- Latency: start bit of byte 0 appears on o_tx the cycle after accept.
- Consecutive bytes are back-to-back: the next start bit begins the cycle after the previous stop bit's final cycle. There is no inter-byte idle.
- Controller FSM states: IDLE, LOAD (present next byte to the TX sub-module), WAIT (byte in flight).
  - IDLE -> LOAD on accept.
  - LOAD -> WAIT in one cycle. This cycle is hidden: the TX sub-module starts from a registered byte so no gap appears.
  - WAIT -> LOAD when the sub-module signals done and bytes remain.
  - WAIT -> IDLE after the last byte.
- Byte counter width: clog2(VALUE_WORDS+2). It wraps only via return to IDLE.
- o_ready returns high on the cycle after the last stop bit completes. Total accept-to-ready = (VALUE_WORDS+1)*(WORD_WIDTH+2)*DIVISOR + 1 cycles.
- Accept on the same cycle ready returns is legal; the next start bit follows immediately.
- o_tx is driven from a flop, never combinational.

Optional Feature:
RESPONSE_CHECKSUM_EN
- Defined: one extra trailing byte equal to the XOR of all preceding frame bytes (addr and all data words). Frame = VALUE_WORDS+2 bytes; the ready latency grows by one character time.
- Undefined: no checksum byte, no checksum logic.

Decomposition:
- Package response_sender_pkg: FSM state enum (IDLE/LOAD/WAIT), FRAME_BYTES localparam function of VALUE_WORDS and the macro, bit-counter and divisor-counter width helpers.
- Sub-module: uart_tx, the single-character transmitter.
  - Parameters: WIDTH, DIVISOR.
  - Ports: clk, i_reset, i_data, i_start, o_tx, o_busy, o_done (1-cycle pulse at end of stop bit).
  - Internal states: IDLE, START, DATA, STOP.
- The parent holds the frame shift register, byte counter and handshake.

Test Plan:
- Reset hold: i_reset=0 for 5 cycles with i_valid=1 -> o_tx=1, o_ready=1, no accept; after release, accept occurs next edge.
- Single frame (WORD_WIDTH=8, VALUE_WORDS=4, DIVISOR=100): addr=0x12, data=0xDEADBEEF.
  - o_tx decodes to bytes 12 DE AD BE EF, each 1000 cycles, no gaps.
  - o_ready high again at cycle 5001 after accept.
- Back-to-back: second response (0x34, 0x00000001) with i_valid held high.
  - Accepted the cycle o_ready returns.
  - Its start bit directly follows the prior stop bit.
  - Bytes 34 00 00 00 01.
- Ignored offer: i_valid pulsed mid-frame with different values -> transmitted frame unchanged; the pulse is not queued.
- Reset mid-frame: i_reset=0 during byte 2 data bits.
  - o_tx=1 next cycle, o_ready=1.
  - A new frame then transmits correctly from byte 0.
- RESPONSE_CHECKSUM_EN defined, same stimulus as single frame -> sixth byte 0x30; o_ready returns at cycle 6001.

Source files
------------

// File: rtl/response_sender_pkg.sv
// Shared types and sizing helpers for the UART response sender.
// RESPONSE_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
package response_sender_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} ctrl_state_e;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Bytes per frame: address, data words, optional checksum.
  function automatic int frame_bytes(input int value_words);
`ifdef RESPONSE_CHECKSUM_EN
    return value_words + 2;
`else
    return value_words + 1;
`endif
  endfunction

  // Bits needed for a counter spanning 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/response_sender_uart_if.sv
// Response handshake plus UART line, bundled for the sender and its driver.
interface response_sender_uart_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4
);
  logic [WORD_WIDTH-1:0]             i_addr;
  logic [VALUE_WORDS*WORD_WIDTH-1:0] i_data;
  logic                              i_valid;
  logic                              o_ready;
  logic                              o_tx;
  logic                              o_busy;

  modport master (output i_addr, i_data, i_valid, input  o_ready, o_tx, o_busy);
  modport slave  (input  i_addr, i_data, i_valid, output o_ready, o_tx, o_busy);
endinterface

// File: rtl/response_sender_uart_tx.sv
// Single-character 8N1-style transmitter; accepts a new start during the
// final stop cycle so consecutive characters run with no idle gap.
module uart_tx
  import response_sender_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 100
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_start,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);
  localparam int DIV_W = idx_width(DIVISOR);
  localparam int BIT_W = idx_width(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             tx_q, tx_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    o_done  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        div_d = '0;
        tx_d  = 1'b1;
        if (i_start) begin
          state_d = TX_START;
          sh_d    = i_data;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d = TX_DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          o_done = 1'b1;
          if (i_start) begin
            state_d = TX_START;
            sh_d    = i_data;
            tx_d    = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q <= TX_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != TX_IDLE);

endmodule

// File: rtl/response_sender_uart.sv
// Serializes one register response (addr, then data MSB word first) onto a
// UART line. Define RESPONSE_CHECKSUM_EN to append an XOR checksum byte.
module response_sender_uart
  import response_sender_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4,
  parameter int DIVISOR     = 100
) (
  input  logic                   clk,
  input  logic                   i_reset,
  response_sender_uart_if.slave  bus
);
  localparam int FRAME = frame_bytes(VALUE_WORDS);
  localparam int SH_W  = (FRAME - 1) * WORD_WIDTH;
  localparam int CNT_W = idx_width(FRAME + 1);

  ctrl_state_e           state_q, state_d;
  logic [SH_W-1:0]       sh_q, sh_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic [SH_W-1:0]       frame_tail;
  logic [WORD_WIDTH-1:0] tx_byte;
  logic                  tx_start, tx_done, tx_busy;
  logic                  accept;

`ifdef RESPONSE_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum;
  always_comb begin
    csum = bus.i_addr;
    for (int i = 0; i < VALUE_WORDS; i++) csum = csum ^ bus.i_data[i*WORD_WIDTH +: WORD_WIDTH];
  end
  assign frame_tail = {bus.i_data, csum};
`else
  assign frame_tail = bus.i_data;
`endif

  assign accept = bus.i_valid && ready_q;

  // The address byte goes straight to the transmitter on accept; the shift
  // register only holds the bytes that follow it.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    tx_start = 1'b0;
    tx_byte  = sh_q[SH_W-1 -: WORD_WIDTH];
    case (state_q)
      IDLE: begin
        tx_byte = bus.i_addr;
        if (accept) begin
          tx_start = 1'b1;
          sh_d     = frame_tail;
          cnt_d    = '0;
          ready_d  = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (cnt_q == CNT_W'(FRAME)) begin
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            tx_start = 1'b1;
            sh_d     = sh_q << WORD_WIDTH;
            state_d  = LOAD;
          end
        end else if (!tx_busy) begin
          // Transmitter lost its character: recover rather than hang.
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  uart_tx #(
    .WIDTH   (WORD_WIDTH),
    .DIVISOR (DIVISOR)
  ) u_tx (
    .clk     (clk),
    .i_reset (i_reset),
    .i_data  (tx_byte),
    .i_start (tx_start),
    .o_tx    (bus.o_tx),
    .o_busy  (tx_busy),
    .o_done  (tx_done)
  );

  assign bus.o_ready = ready_q;
  assign bus.o_busy  = !ready_q;

endmodule

// File: tb/tb_response_sender_uart.sv
// Directed bench: reset hold, single frame, ignored offer, back-to-back
// accept, mid-frame reset and a fresh frame afterwards.
module tb_response_sender_uart;
  localparam int W    = 8;
  localparam int VW   = 4;
  localparam int DIV  = 100;
  localparam int CHAR = (W + 2) * DIV;
`ifdef RESPONSE_CHECKSUM_EN
  localparam int NB = VW + 2;
  localparam logic [63:0] F1 = 64'h12DEADBEEF30;
  localparam logic [63:0] F2 = 64'h340000000135;
  localparam logic [63:0] F3 = 64'hA50102807F59;
`else
  localparam int NB = VW + 1;
  localparam logic [63:0] F1 = 64'h12DEADBEEF;
  localparam logic [63:0] F2 = 64'h3400000001;
  localparam logic [63:0] F3 = 64'hA50102807F;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc1, acc2, acc3;

  response_sender_uart_if #(.WORD_WIDTH(W), .VALUE_WORDS(VW)) bus ();

  response_sender_uart #(.WORD_WIDTH(W), .VALUE_WORDS(VW), .DIVISOR(DIV)) dut (
    .clk     (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Checks the first and last cycle of every bit of a frame up to obs base+lim.
  task automatic chk_frame(input int base, input logic [63:0] fr, input int lim);
    logic [7:0] b8;
    logic       e;
    int         t;
    for (int b = 0; b < NB; b++) begin
      b8 = fr[8*(NB-1-b) +: 8];
      for (int k = 0; k < 10; k++) begin
        for (int o = 0; o < 2; o++) begin
          t = b*CHAR + k*DIV + o*(DIV-1);
          if (t <= lim) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b8[k-1];
            wait_to(base + t);
            chk($sformatf("tx byte%0d bit%0d edge%0d", b, k, o), bus.o_tx, e);
          end
        end
      end
    end
  endtask

  task automatic send_wait(output int acc);
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus.o_ready, 1);
    acc = cyc + 1;
  endtask

  initial begin
    bus.i_addr  = 8'h12;
    bus.i_data  = 32'hDEADBEEF;
    bus.i_valid = 1'b1;
    rst_n       = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_tx", bus.o_tx, 1);
      chk("rst_ready", bus.o_ready, 1);
    end
    chk("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    send_wait(acc1);

    fork
      chk_frame(acc1, F1, NB*CHAR - 1);
      begin
        wait_to(acc1);
        chk("ready_drop", bus.o_ready, 0);
        chk("busy_up", bus.o_busy, 1);
        bus.i_valid = 1'b0;
        wait_to(acc1 + 2*CHAR + 300);
        bus.i_addr  = 8'h99;
        bus.i_data  = 32'h11223344;
        bus.i_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        bus.i_addr  = 8'h34;
        bus.i_data  = 32'h00000001;
        bus.i_valid = 1'b1;
        wait_to(acc1 + NB*CHAR - 1);
        chk("ready_early", bus.o_ready, 0);
        wait_to(acc1 + NB*CHAR);
        chk("ready_return", bus.o_ready, 1);
        chk("idle_line", bus.o_tx, 1);
      end
    join

    acc2 = acc1 + NB*CHAR + 1;
    fork
      chk_frame(acc2, F2, 2*CHAR + 299);
      begin
        wait_to(acc2);
        chk("b2b_accept", bus.o_ready, 0);
        bus.i_valid = 1'b0;
        wait_to(acc2 + 2*CHAR + 300);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", bus.o_tx, 1);
        chk("midrst_ready", bus.o_ready, 1);
        chk("midrst_busy", bus.o_busy, 0);
        rst_n = 1'b1;
      end
    join

    bus.i_addr  = 8'hA5;
    bus.i_data  = 32'h0102807F;
    bus.i_valid = 1'b1;
    send_wait(acc3);
    fork
      chk_frame(acc3, F3, NB*CHAR - 1);
      begin
        wait_to(acc3);
        bus.i_valid = 1'b0;
        wait_to(acc3 + NB*CHAR - 1);
        chk("f3_ready_early", bus.o_ready, 0);
        wait_to(acc3 + NB*CHAR);
        chk("f3_ready_return", bus.o_ready, 1);
      end
    join

    repeat (3) @(negedge clk);
    chk("final_idle", bus.o_tx, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
